iob_dma_fifo_wr_master: RTL

IOB_DMA_FIFO_WR_MASTER -- requirements
Module: iob_dma_fifo_wr_master

---
 rtl/iob_dma_pkg.sv | 21 ++
 rtl/iob_dma_fifo_wr_master.sv | 99 +++++++++
 2 files changed

// File: rtl/iob_dma_pkg.sv
// Shared DMA definitions: FSM state encoding and word-size constants
// used by the DMA engine and its FIFO-to-memory write master.
package iob_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_WRITE,
    ST_DONE
  } dma_state_e;

  localparam int unsigned DMA_DATA_W = 32;

  function automatic int unsigned bytes_per_word(
    input int unsigned data_w
  );
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_dma_fifo_wr_master.sv
// Pops words from a FIFO and writes them to consecutive addresses
// on a native valid/ready master port, one word in flight at a time.
module iob_dma_fifo_wr_master
  import iob_dma_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = DMA_DATA_W,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_read_en,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic              m_ready
);

  localparam int unsigned BPW   = bytes_per_word(DATA_W);
  localparam int unsigned SHIFT = $clog2(BPW);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  words;

  // Sub-word remainder of the byte length is dropped.
  assign words = length >> SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    busy         = 1'b1;
    done         = 1'b0;
    fifo_read_en = 1'b0;
    m_valid      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          addr_d  = base_addr;
          cnt_d   = words;
          state_d = (words == '0) ? ST_DONE : ST_POP;
        end
      end
      ST_POP: begin
        fifo_read_en = !fifo_empty;
        if (!fifo_empty) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        data_d  = fifo_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        m_valid = 1'b1;
        if (m_ready) begin
          addr_d  = addr_q + ADDR_W'(BPW);
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_POP;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_addr  = addr_q;
  assign m_wdata = data_q;
  assign m_wstrb = m_valid ? '1 : '0;

endmodule
